// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the CPU memory bus: latches a Read/Write
// request from MAR/MDR, inserts WAIT_STATES wait cycles, performs one access, then holds Done.
module mem_responder #(
  parameter int unsigned ADDR_BITS   = 9,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Read,
  input  logic                  Write,
  input  logic [31:0]           Address,
  input  logic [DATA_WIDTH-1:0] DataIn,
  output logic [DATA_WIDTH-1:0] DataOut,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Error
);

  localparam int unsigned DEPTH = 2 ** ADDR_BITS;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_BITS-1:0]    r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic                    r_is_write;
  logic                    r_illegal;
  logic [CNT_W-1:0]        r_cnt;
  logic [DATA_WIDTH-1:0]   r_data_out;
  logic                    r_done;
  logic                    r_error;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];
  logic                    w_req;
  logic                    w_ram_we;

  // Memory image at time zero: zeros.
  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) r_mem[ADDR_BITS'(i)] = '0;
  end

  assign w_req    = Read || Write;
  assign w_ram_we = (r_state == S_ACCESS) && r_is_write && !r_illegal;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_next = (WAIT_STATES != 0) ? S_WAIT : S_ACCESS;
      S_WAIT:   if (r_cnt == CNT_W'(1)) w_next = S_ACCESS;
      S_ACCESS: w_next = S_DONE;
      S_DONE:   if (!w_req) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Request capture, wait counting and registered responses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_is_write <= 1'b0;
      r_illegal  <= 1'b0;
      r_cnt      <= '0;
      r_data_out <= '0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_addr     <= Address[ADDR_BITS-1:0];
            r_wdata    <= DataIn;
            r_is_write <= Write;
            r_illegal  <= (Read && Write) || (Address[31:ADDR_BITS] != '0);
            r_cnt      <= CNT_W'(WAIT_STATES);
          end
        end
        S_WAIT: r_cnt <= r_cnt - CNT_W'(1);
        S_ACCESS: begin
          r_done <= 1'b1;
          if (r_illegal) begin
            r_error    <= 1'b1;
            r_data_out <= '0;
          end else if (!r_is_write) begin
            r_data_out <= r_mem[r_addr];
          end
        end
        S_DONE: begin
          if (!w_req) begin
            r_done  <= 1'b0;
            r_error <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM is deliberately outside the reset domain so its contents survive Reset.
  always_ff @(posedge Clock) begin
    if (w_ram_we) r_mem[r_addr] <= r_wdata;
  end

  assign DataOut = r_data_out;
  assign Done    = r_done;
  assign Error   = r_error;
  assign Busy    = (r_state != S_IDLE);

endmodule
